// File: rtl/fir_ser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_ser_pkg: shared FSM encoding and width helper for serial TX arb. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fir_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_STREAM = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int safe_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ser_rr_picker: combinational round-robin winner select.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ser_rr_picker
  import fir_ser_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int GW    = safe_w(N_REQ)
) (
  input  logic [N_REQ-1:0] iv_req,
  input  logic [GW-1:0]    iv_rr_ptr,
  output logic [GW-1:0]    ov_win_id,
  output logic             o_any
);

  logic          w_hit;
  logic [GW-1:0] w_hi_id;
  logic [GW-1:0] w_lo_id;

  // Descending scan: the last match written is the lowest index.
  always_comb begin
    o_any   = 1'b0;
    w_hit   = 1'b0;
    w_hi_id = '0;
    w_lo_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (iv_req[i]) begin
        o_any   = 1'b1;
        w_lo_id = GW'(i);
        if (i >= int'(iv_rr_ptr)) begin
          w_hit   = 1'b1;
          w_hi_id = GW'(i);
        end
      end
    end
    ov_win_id = w_hit ? w_hi_id : w_lo_id;
  end

endmodule
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_tx_arbiter: round-robin share of one bit-serial transmitter.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module serial_tx_arbiter
  import fir_ser_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int LENGTH = 8,
  localparam int GW     = safe_w(N_REQ),
  localparam int CW     = $clog2(LENGTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [N_REQ-1:0]        iv_req,
  input  logic [N_REQ*LENGTH-1:0] iv_data,
  output logic [N_REQ-1:0]        ov_ack,
  output logic [GW-1:0]           ov_gnt_id,
  output logic                    o_busy,
  output logic [LENGTH-1:0]       ov_ser_din,
  output logic                    o_ser_din_valid,
  input  logic                    i_ser_ready,
  input  logic                    i_ser_dout_valid,
  input  logic                    i_sink_ready
);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [LENGTH-1:0] din_q, din_d;
  logic              vld_q, vld_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;

  logic [GW-1:0]     w_win_id;
  logic              w_any;

  ser_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .iv_req    (iv_req),
    .iv_rr_ptr (rr_ptr_q),
    .ov_win_id (w_win_id),
    .o_any     (w_any)
  );

  // i_en low freezes everything, which also stretches a pending ack pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      ack_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      din_q     <= '0;
      vld_q     <= 1'b0;
      rr_ptr_q  <= '0;
      bit_cnt_q <= '0;
    end else if (i_en) begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      din_q     <= din_d;
      vld_q     <= vld_d;
      rr_ptr_q  <= rr_ptr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    gnt_d     = gnt_q;
    din_d     = din_q;
    vld_d     = vld_q;
    rr_ptr_d  = rr_ptr_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          din_d           = iv_data[int'(w_win_id)*LENGTH +: LENGTH];
          gnt_d           = w_win_id;
          ack_d[w_win_id] = 1'b1;
          vld_d           = 1'b1;
          state_d         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_ser_ready) begin
          vld_d     = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (i_ser_dout_valid && i_sink_ready) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(LENGTH - 1)) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // Rotate past the grantee so a still-high request yields to others.
        rr_ptr_d = (gnt_q == GW'(N_REQ - 1)) ? '0 : gnt_q + GW'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign ov_ack          = ack_q;
  assign ov_gnt_id       = gnt_q;
  assign o_busy          = busy_q;
  assign ov_ser_din      = din_q;
  assign o_ser_din_valid = vld_q;

endmodule
`default_nettype wire
